// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mc_ctrl_pkg
// Description : State codes, opcode/funct constants and ALU encodings shared
//               by the multicycle control FSM and its ALU decoder.
// Revision    : 1.0
// ============================================================================
package mc_ctrl_pkg;

    localparam int MC_STATE_W = 4;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEX   = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps the FSM's aluop and the instruction funct field onto the
//               4-bit ALU control code.
// Revision    : 1.0
// ============================================================================
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [3:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control FSM for the multicycle datapath: state register,
//               next-state logic, Moore output decode and PC-enable gating.
//               Build option MC_ADDI_EN adds the addi path (ADDIEX/ADDIWB).
// Revision    : 1.0
// ============================================================================
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = MC_STATE_W
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [3:0]         alucontrol,
    output logic [STATE_W-1:0] state
);

    logic [3:0] r_state;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_aluen;
    logic [1:0] w_aluop;
    logic [3:0] w_dec_alu;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXECUTE;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
`ifdef MC_ADDI_EN
                        OP_ADDI:      r_state <= S_ADDIEX;
`endif
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  r_state <= S_MEMWB;
                S_EXECUTE:  r_state <= S_ALUWB;
`ifdef MC_ADDI_EN
                S_ADDIEX:   r_state <= S_ADDIWB;
`endif
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        w_aluen   = 1'b0;
        w_aluop   = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                irwrite   = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = 2'b01;
                w_aluen   = 1'b1;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                w_aluen = 1'b1;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_aluen = 1'b1;
            end
            S_MEMREAD:  iord = 1'b1;
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWRITE: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                w_aluen = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
                w_aluen  = 1'b1;
                w_aluop  = ALUOP_SUB;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_aluen = 1'b1;
            end
            S_ADDIWB:   regwrite = 1'b1;
`endif
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides the decode so an aborted instruction commits nothing
        if (reset) begin
            iord      = 1'b0;
            memwrite  = 1'b0;
            irwrite   = 1'b0;
            regdst    = 1'b0;
            memtoreg  = 1'b0;
            regwrite  = 1'b0;
            alusrca   = 1'b0;
            alusrcb   = 2'b00;
            pcsrc     = 2'b00;
            w_pcwrite = 1'b0;
            w_branch  = 1'b0;
            w_aluen   = 1'b1;
            w_aluop   = ALUOP_ADD;
        end
        pcen = w_pcwrite | (w_branch & zero);
    end

    alu_decoder u_alu_decoder (
        .funct      (funct),
        .aluop      (w_aluop),
        .alucontrol (w_dec_alu)
    );

    assign alucontrol = w_aluen ? w_dec_alu : ALU_AND;
    assign state      = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed bench with a per-state control model and literal
//               sequence signatures for multicycle_controller.
// Revision    : 1.0
// ============================================================================
module tb_multicycle_controller;

    typedef int iq_t[$];

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [3:0] alucontrol;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic       regdst;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol;
    logic [3:0] state;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_valid = 1'b0;
    logic exp_st_valid = 1'b0;
    logic exp_rst = 1'b1;
    int   exp_st = 0;
    obs_t obs[$];

    always #5 clk = ~clk;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .state(state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            default:   return 4'b0010;
        endcase
    endfunction

    // What every output must be in a given state, straight from the state table
    function automatic ctrl_t model_ctrl(input int st, input logic [5:0] f, input logic z, input logic rst);
        ctrl_t c;
        c = '0;
        if (rst) begin
            c.alucontrol = 4'b0010;
            return c;
        end
        case (st)
            0:  begin c.irwrite = 1; c.pcen = 1; c.alusrcb = 2'b01; c.alucontrol = 4'b0010; end
            1:  begin c.alusrcb = 2'b11; c.alucontrol = 4'b0010; end
            2:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 4'b0010; end
            3:  c.iord = 1;
            4:  begin c.regwrite = 1; c.memtoreg = 1; end
            5:  begin c.iord = 1; c.memwrite = 1; end
            6:  begin c.alusrca = 1; c.alucontrol = funct_alu(f); end
            7:  begin c.regwrite = 1; c.regdst = 1; end
            8:  begin c.alusrca = 1; c.alucontrol = 4'b0110; c.pcsrc = 2'b01; c.pcen = z; end
            9:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 4'b0010; end
            10: c.regwrite = 1;
            11: begin c.pcsrc = 2'b10; c.pcen = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic iq_t path_of(input logic [5:0] o);
        case (o)
            6'b100011: return '{0, 1, 2, 3, 4};
            6'b101011: return '{0, 1, 2, 5};
            6'b000000: return '{0, 1, 6, 7};
            6'b000100: return '{0, 1, 8};
            6'b000010: return '{0, 1, 11};
`ifdef MC_ADDI_EN
            6'b001000: return '{0, 1, 9, 10};
`endif
            default:   return '{0, 1};
        endcase
    endfunction

    // Signature of one observed field across the last instruction, first cycle in the MSBs
    function automatic logic [63:0] sig(input int fld);
        logic [63:0] s;
        s = '0;
        foreach (obs[i]) begin
            case (fld)
                0: s = {s[59:0], obs[i].st};
                1: s = {s[62:0], obs[i].iord};
                2: s = {s[62:0], obs[i].memwrite};
                3: s = {s[62:0], obs[i].regwrite};
                4: s = {s[62:0], obs[i].memtoreg};
                5: s = {s[62:0], obs[i].regdst};
                default: s = {s[62:0], obs[i].pcen};
            endcase
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            ctrl_t e;
            ctrl_t a;
            e = model_ctrl(exp_st, funct, zero, exp_rst);
            a = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, alucontrol};
            if (exp_st_valid)
                chk($sformatf("state(exp %0d)", exp_st), 64'(state), 64'(exp_st));
            chk($sformatf("ctrl@st%0d rst%0b", exp_st, exp_rst), 64'(a), 64'(e));
            obs.push_back('{state, alucontrol, pcsrc, pcen, iord, memwrite, regwrite, memtoreg, regdst});
        end
    end

    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int lat);
        iq_t p;
        p = path_of(o);
        op = o;
        funct = f;
        zero = z;
        obs.delete();
        foreach (p[i]) begin
            exp_st = p[i];
            @(posedge clk);
            #1;
        end
        exp_st = 0;
        chk({name, "_latency"}, 64'(p.size()), 64'(lat));
        chk({name, "_back_to_fetch"}, 64'(state), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        op = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        exp_rst = 1'b1;
        exp_st = 0;
        exp_valid = 1'b1;
        @(posedge clk); #1;
        exp_st_valid = 1'b1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_enables", 64'({pcen, irwrite, regwrite, memwrite}), 64'd0);
        chk("rst_alucontrol", 64'(alucontrol), 64'h2);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rst = 1'b0;
        #1;
        chk("fetch_en", 64'({pcen, irwrite, alusrcb}), 64'b1101);

        run_instr("lw", 6'b100011, 6'd0, 1'b0, 5);
        chk("lw_seq", sig(0), 64'h01234);
        chk("lw_iord", sig(1), 64'b00010);
        chk("lw_regwrite", sig(3), 64'b00001);
        chk("lw_memtoreg", sig(4), 64'b00001);

        run_instr("rsub", 6'b000000, 6'b100010, 1'b0, 4);
        chk("rsub_seq", sig(0), 64'h0167);
        chk("rsub_alu", 64'(obs[2].alu), 64'b0110);
        chk("rsub_regwrite", sig(3), 64'b0001);
        chk("rsub_regdst", sig(5), 64'b0001);

        run_instr("rbad", 6'b000000, 6'b111111, 1'b0, 4);
        chk("rbad_alu", 64'(obs[2].alu), 64'b0010);
        run_instr("rand", 6'b000000, 6'b100100, 1'b0, 4);
        chk("rand_alu", 64'(obs[2].alu), 64'b0000);
        run_instr("ror", 6'b000000, 6'b100101, 1'b0, 4);
        chk("ror_alu", 64'(obs[2].alu), 64'b0001);
        run_instr("radd", 6'b000000, 6'b100000, 1'b1, 4);
        chk("radd_alu", 64'(obs[2].alu), 64'b0010);

        run_instr("beq_taken", 6'b000100, 6'd0, 1'b1, 3);
        chk("beq_taken_seq", sig(0), 64'h018);
        chk("beq_taken_pcen", sig(6), 64'b101);
        chk("beq_taken_pcsrc", 64'(obs[2].pcsrc), 64'b01);
        run_instr("beq_not", 6'b000100, 6'd0, 1'b0, 3);
        chk("beq_not_pcen", sig(6), 64'b100);

        run_instr("j", 6'b000010, 6'd0, 1'b0, 3);
        chk("j_seq", sig(0), 64'h01b);
        chk("j_pcen", sig(6), 64'b101);
        chk("j_pcsrc", 64'(obs[2].pcsrc), 64'b10);

        run_instr("sw", 6'b101011, 6'd0, 1'b0, 4);
        chk("sw_seq", sig(0), 64'h0125);
        chk("sw_memwrite", sig(2), 64'b0001);

        run_instr("illegal", 6'b111111, 6'd0, 1'b1, 2);
        chk("illegal_seq", sig(0), 64'h01);
        chk("illegal_writes", 64'({sig(2), sig(3)}), 64'd0);

`ifdef MC_ADDI_EN
        run_instr("addi", 6'b001000, 6'd0, 1'b0, 4);
        chk("addi_seq", sig(0), 64'h019a);
        chk("addi_regwrite", sig(3), 64'b0001);
`else
        run_instr("addi", 6'b001000, 6'd0, 1'b0, 2);
        chk("addi_seq", sig(0), 64'h01);
        chk("addi_regwrite", sig(3), 64'b00);
`endif

        // sw aborted by reset while in MEMWRITE
        op = 6'b101011;
        exp_st = 0; @(posedge clk); #1;
        exp_st = 1; @(posedge clk); #1;
        exp_st = 2; @(posedge clk); #1;
        exp_st = 5;
        reset = 1'b1;
        exp_rst = 1'b1;
        #1;
        chk("abort_state", 64'(state), 64'd5);
        chk("abort_memwrite", 64'(memwrite), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rst = 1'b0;
        exp_st = 0;
        chk("abort_next_state", 64'(state), 64'd0);
        @(posedge clk); #1;
        exp_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
